// File: rtl/usart_frame_recv_if.sv
// Decoded-frame bundle of the UART frame receiver: serial line in, byte and
// frame results out.
interface usart_frame_recv_if;
    logic        uart_rxd;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [23:0] D;
    logic [1:0]  Adress;
    logic [5:0]  Mod_SEL;
    logic        frame_valid;
    logic        frame_err;

    modport master (
        input  uart_rxd,
        output rx_data, rx_done, D, Adress, Mod_SEL, frame_valid, frame_err
    );

    modport slave (
        output uart_rxd,
        input  rx_data, rx_done, D, Adress, Mod_SEL, frame_valid, frame_err
    );
endinterface

// File: rtl/usart_frame_recv.sv
// 8N1 UART receiver plus decoder for the 7-byte status frame
// FF, addr, mode, D2, D1, D0, AA; publishes D/Adress/Mod_SEL on a good frame.
module usart_frame_recv #(
    parameter logic [15:0] BPS_CNT     = 16'd434,
    parameter logic [15:0] TIMEOUT_CNT = 16'd12000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    usart_frame_recv_if.master bus
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {FR_HUNT, FR_ADDR, FR_MOD, FR_D2, FR_D1, FR_D0, FR_TAIL} fr_state_t;

    localparam logic [15:0] HALF_CNT = BPS_CNT >> 1;
    localparam logic [15:0] LAST_CNT = BPS_CNT - 16'd1;
    localparam logic [15:0] TMO_LAST = TIMEOUT_CNT - 16'd1;

    logic        sync1_r, sync2_r, rxd_prev_r;
    logic        rxd_s, fall_s, mid_s, end_s;
    rx_state_t   rx_state_r, rx_state_nxt_s;
    logic [15:0] bit_cnt_r, bit_cnt_nxt_s;
    logic [2:0]  bit_idx_r, bit_idx_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic [7:0]  rx_data_r, rx_data_nxt_s;
    logic        rx_done_r, rx_done_nxt_s;
    logic        byte_err_r, byte_err_nxt_s;

    fr_state_t   fr_state_r, fr_state_nxt_s;
    logic [7:0]  addr_sh_r, addr_sh_nxt_s;
    logic [7:0]  mode_sh_r, mode_sh_nxt_s;
    logic [7:0]  d2_sh_r, d2_sh_nxt_s;
    logic [7:0]  d1_sh_r, d1_sh_nxt_s;
    logic [7:0]  d0_sh_r, d0_sh_nxt_s;
    logic [23:0] d_r, d_nxt_s;
    logic [1:0]  adress_r, adress_nxt_s;
    logic [5:0]  mod_sel_r, mod_sel_nxt_s;
    logic        fv_r, fv_nxt_s;
    logic        fe_r, fe_nxt_s;
    logic [15:0] tmo_cnt_r, tmo_nxt_s;
    logic        tmo_exp_s, tail_ok_s;

    assign rxd_s     = sync2_r;
    assign fall_s    = rxd_prev_r & ~sync2_r;
    assign mid_s     = (bit_cnt_r == HALF_CNT);
    assign end_s     = (bit_cnt_r == LAST_CNT);
    assign tmo_exp_s = (fr_state_r != FR_HUNT) && (tmo_cnt_r == TMO_LAST);
    assign tail_ok_s = (rx_data_r == 8'hAA) && (addr_sh_r[7:2] == 6'd0) && (mode_sh_r[7:6] == 2'd0);

    // Line synchronizer; the extra stage gives the previous value for edge detect.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync1_r    <= 1'b1;
            sync2_r    <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            sync1_r    <= bus.uart_rxd;
            sync2_r    <= sync1_r;
            rxd_prev_r <= sync2_r;
        end
    end

    // Bit-level receiver next state; a bad stop returns to IDLE at mid-bit and
    // the edge detector then needs the line to go high again.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        bit_idx_nxt_s  = bit_idx_r;
        shift_nxt_s    = shift_r;
        rx_data_nxt_s  = rx_data_r;
        rx_done_nxt_s  = 1'b0;
        byte_err_nxt_s = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                bit_cnt_nxt_s = 16'd0;
                bit_idx_nxt_s = 3'd0;
                if (fall_s) rx_state_nxt_s = RX_START;
                else        rx_state_nxt_s = RX_IDLE;
            end
            RX_START: begin
                if (mid_s && rxd_s) begin
                    rx_state_nxt_s = RX_IDLE;
                    bit_cnt_nxt_s  = 16'd0;
                end else if (end_s) begin
                    rx_state_nxt_s = RX_DATA;
                    bit_cnt_nxt_s  = 16'd0;
                end else begin
                    bit_cnt_nxt_s  = bit_cnt_r + 16'd1;
                end
            end
            RX_DATA: begin
                if (mid_s) shift_nxt_s = {rxd_s, shift_r[7:1]};
                else       shift_nxt_s = shift_r;
                if (end_s) begin
                    bit_cnt_nxt_s = 16'd0;
                    if (bit_idx_r == 3'd7) rx_state_nxt_s = RX_STOP;
                    else                   bit_idx_nxt_s  = bit_idx_r + 3'd1;
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + 16'd1;
                end
            end
            RX_STOP: begin
                if (mid_s) begin
                    rx_state_nxt_s = RX_IDLE;
                    bit_cnt_nxt_s  = 16'd0;
                    if (rxd_s) begin
                        rx_data_nxt_s = shift_r;
                        rx_done_nxt_s = 1'b1;
                    end else begin
                        byte_err_nxt_s = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + 16'd1;
                end
            end
            default: begin
                rx_state_nxt_s = RX_IDLE;
                bit_cnt_nxt_s  = 16'd0;
            end
        endcase
    end

    // Bit-level receiver registers.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            rx_state_r <= RX_IDLE;
            bit_cnt_r  <= 16'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            rx_data_r  <= 8'd0;
            rx_done_r  <= 1'b0;
            byte_err_r <= 1'b0;
        end else begin
            rx_state_r <= rx_state_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            shift_r    <= shift_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rx_done_r  <= rx_done_nxt_s;
            byte_err_r <= byte_err_nxt_s;
        end
    end

    // Frame decoder next state; an accepted byte outranks a same-cycle timeout.
    always_comb begin
        fr_state_nxt_s = fr_state_r;
        addr_sh_nxt_s  = addr_sh_r;
        mode_sh_nxt_s  = mode_sh_r;
        d2_sh_nxt_s    = d2_sh_r;
        d1_sh_nxt_s    = d1_sh_r;
        d0_sh_nxt_s    = d0_sh_r;
        d_nxt_s        = d_r;
        adress_nxt_s   = adress_r;
        mod_sel_nxt_s  = mod_sel_r;
        fv_nxt_s       = 1'b0;
        fe_nxt_s       = 1'b0;
        tmo_nxt_s      = tmo_cnt_r;
        if (rx_done_r) begin
            tmo_nxt_s = 16'd0;
            case (fr_state_r)
                FR_HUNT: begin
                    if (rx_data_r == 8'hFF) fr_state_nxt_s = FR_ADDR;
                    else                    fr_state_nxt_s = FR_HUNT;
                end
                FR_ADDR: begin addr_sh_nxt_s = rx_data_r; fr_state_nxt_s = FR_MOD;  end
                FR_MOD:  begin mode_sh_nxt_s = rx_data_r; fr_state_nxt_s = FR_D2;   end
                FR_D2:   begin d2_sh_nxt_s   = rx_data_r; fr_state_nxt_s = FR_D1;   end
                FR_D1:   begin d1_sh_nxt_s   = rx_data_r; fr_state_nxt_s = FR_D0;   end
                FR_D0:   begin d0_sh_nxt_s   = rx_data_r; fr_state_nxt_s = FR_TAIL; end
                FR_TAIL: begin
                    fr_state_nxt_s = FR_HUNT;
                    if (tail_ok_s) begin
                        fv_nxt_s      = 1'b1;
                        d_nxt_s       = {d2_sh_r, d1_sh_r, d0_sh_r};
                        adress_nxt_s  = addr_sh_r[1:0];
                        mod_sel_nxt_s = mode_sh_r[5:0];
                    end else begin
                        fe_nxt_s = 1'b1;
                    end
                end
                default: fr_state_nxt_s = FR_HUNT;
            endcase
        end else if (byte_err_r && (fr_state_r != FR_HUNT)) begin
            fe_nxt_s       = 1'b1;
            fr_state_nxt_s = FR_HUNT;
            tmo_nxt_s      = 16'd0;
        end else if (tmo_exp_s) begin
            fe_nxt_s       = 1'b1;
            fr_state_nxt_s = FR_HUNT;
            tmo_nxt_s      = 16'd0;
        end else if (fr_state_r != FR_HUNT) begin
            tmo_nxt_s = tmo_cnt_r + 16'd1;
        end else begin
            tmo_nxt_s = 16'd0;
        end
    end

    // Frame decoder registers and published outputs.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            fr_state_r <= FR_HUNT;
            addr_sh_r  <= 8'd0;
            mode_sh_r  <= 8'd0;
            d2_sh_r    <= 8'd0;
            d1_sh_r    <= 8'd0;
            d0_sh_r    <= 8'd0;
            d_r        <= 24'd0;
            adress_r   <= 2'd0;
            mod_sel_r  <= 6'd0;
            fv_r       <= 1'b0;
            fe_r       <= 1'b0;
            tmo_cnt_r  <= 16'd0;
        end else begin
            fr_state_r <= fr_state_nxt_s;
            addr_sh_r  <= addr_sh_nxt_s;
            mode_sh_r  <= mode_sh_nxt_s;
            d2_sh_r    <= d2_sh_nxt_s;
            d1_sh_r    <= d1_sh_nxt_s;
            d0_sh_r    <= d0_sh_nxt_s;
            d_r        <= d_nxt_s;
            adress_r   <= adress_nxt_s;
            mod_sel_r  <= mod_sel_nxt_s;
            fv_r       <= fv_nxt_s;
            fe_r       <= fe_nxt_s;
            tmo_cnt_r  <= tmo_nxt_s;
        end
    end

    assign bus.rx_data     = rx_data_r;
    assign bus.rx_done     = rx_done_r;
    assign bus.D           = d_r;
    assign bus.Adress      = adress_r;
    assign bus.Mod_SEL     = mod_sel_r;
    assign bus.frame_valid = fv_r;
    assign bus.frame_err   = fe_r;

endmodule

// File: tb/tb_usart_frame_recv.sv
// Directed bench for usart_frame_recv: byte/frame-level model compared every
// cycle, plus literal checks of decoded values and strobe counts.
module tb_usart_frame_recv;

    localparam int BPS = 48;
    localparam int TMO = 1200;
    // Pin edge to rx_done high: 2 sync stages + edge register, 9 full bits, half a stop bit.
    localparam int LAT = 4 + 9 * BPS + BPS / 2;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   fv_cnt  = 0;
    int   fe_cnt  = 0;
    int   rxd_cnt = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    usart_frame_recv_if bus ();

    usart_frame_recv #(.BPS_CNT(16'(BPS)), .TIMEOUT_CNT(16'(TMO))) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    typedef struct {
        int         t;
        logic [7:0] b;
        bit         ok;
    } ev_t;
    ev_t evq[$];

    // Frame model: position in frame (0 = hunting), captured bytes, published values
    int          pos = 0;
    logic [7:0]  sh [1:5];
    int          last_t = 0;
    logic [23:0] m_d = 24'd0;
    logic [1:0]  m_a = 2'd0;
    logic [5:0]  m_m = 6'd0;
    logic [7:0]  m_rxd = 8'd0;
    bit          pend_fv = 1'b0, pend_fe = 1'b0;
    logic [23:0] p_d;
    logic [1:0]  p_a;
    logic [5:0]  p_m;

    task automatic check_vec(input string name, input logic [42:0] act, input logic [42:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        last_t = cyc;
        if (pos == 0) begin
            if (b == 8'hFF) pos = 1;
        end else if (pos < 6) begin
            sh[pos] = b;
            pos++;
        end else begin
            if (b == 8'hAA && sh[1][7:2] == 6'd0 && sh[2][7:6] == 2'd0) begin
                pend_fv = 1'b1;
                p_d = {sh[3], sh[4], sh[5]};
                p_a = sh[1][1:0];
                p_m = sh[2][5:0];
            end else begin
                pend_fe = 1'b1;
            end
            pos = 0;
        end
    endtask

    // Per-cycle comparison of every output against the model
    initial begin
        logic [42:0] act, exp;
        bit   cur_fv, cur_fe, exp_done, had_ev;
        ev_t  ev;
        forever begin
            @(negedge sys_clk);
            act = {bus.rx_done, bus.rx_data, bus.frame_valid, bus.frame_err, bus.D, bus.Adress, bus.Mod_SEL};
            fv_cnt  += int'(bus.frame_valid);
            fe_cnt  += int'(bus.frame_err);
            rxd_cnt += int'(bus.rx_done);
            if (!sys_rst) begin
                pos = 0; m_d = 24'd0; m_a = 2'd0; m_m = 6'd0; m_rxd = 8'd0;
                pend_fv = 1'b0; pend_fe = 1'b0;
                evq.delete();
                check_vec("reset_outputs", act, 43'd0);
            end else begin
                cur_fv = pend_fv;
                cur_fe = pend_fe;
                if (pend_fv) begin
                    m_d = p_d; m_a = p_a; m_m = p_m;
                end
                pend_fv  = 1'b0;
                pend_fe  = 1'b0;
                exp_done = 1'b0;
                had_ev   = 1'b0;
                if (evq.size() > 0 && evq[0].t == cyc) begin
                    ev = evq.pop_front();
                    had_ev = 1'b1;
                    if (ev.ok) begin
                        exp_done = 1'b1;
                        m_rxd = ev.b;
                        model_byte(ev.b);
                    end else if (pos != 0) begin
                        pend_fe = 1'b1;
                        pos = 0;
                    end
                end
                if (!had_ev && pos != 0 && (cyc - last_t) == TMO) begin
                    pend_fe = 1'b1;
                    pos = 0;
                end
                exp = {exp_done, m_rxd, cur_fv, cur_fe, m_d, m_a, m_m};
                check_vec("outputs", act, exp);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        e.t = cyc + LAT; e.b = b; e.ok = stop_ok;
        evq.push_back(e);
        bus.uart_rxd = 1'b0;
        idle(BPS);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rxd = b[i];
            idle(BPS);
        end
        bus.uart_rxd = stop_ok;
        idle(BPS);
        bus.uart_rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] a, m, d2, d1, d0, tl);
        send_byte(8'hFF, 1'b1);
        send_byte(a, 1'b1);
        send_byte(m, 1'b1);
        send_byte(d2, 1'b1);
        send_byte(d1, 1'b1);
        send_byte(d0, 1'b1);
        send_byte(tl, 1'b1);
    endtask

    task automatic chk_outs(input string tag, input int d, input int a, input int m);
        chk_lit({tag, "_D"}, int'(bus.D), d);
        chk_lit({tag, "_Adress"}, int'(bus.Adress), a);
        chk_lit({tag, "_Mod_SEL"}, int'(bus.Mod_SEL), m);
    endtask

    initial begin
        bus.uart_rxd = 1'b1;
        sys_rst = 1'b0;
        idle(5);
        sys_rst = 1'b1;
        idle(10);
        chk_outs("reset", 0, 0, 0);

        send_frame(8'h01, 8'h2A, 8'h12, 8'h34, 8'h56, 8'hAA);
        idle(20);
        chk_outs("good", 24'h123456, 1, 8'h2A);
        chk_lit("good_fv", fv_cnt, 1);
        chk_lit("good_rxd", rxd_cnt, 7);

        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b1);
        send_frame(8'h03, 8'h3F, 8'hAB, 8'hCD, 8'hEF, 8'hAA);
        idle(20);
        chk_outs("junk", 24'hABCDEF, 3, 8'h3F);
        chk_lit("junk_fv", fv_cnt, 2);

        send_frame(8'h01, 8'h2A, 8'h12, 8'h34, 8'h56, 8'hAB);
        idle(20);
        chk_lit("badtail_fe", fe_cnt, 1);
        chk_outs("badtail", 24'hABCDEF, 3, 8'h3F);
        send_frame(8'h05, 8'h2A, 8'h12, 8'h34, 8'h56, 8'hAA);
        idle(20);
        chk_lit("badaddr_fe", fe_cnt, 2);
        chk_lit("badaddr_fv", fv_cnt, 2);

        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h2A, 1'b1);
        idle(TMO + 100);
        chk_lit("timeout_fe", fe_cnt, 3);
        send_frame(8'h02, 8'h15, 8'h0A, 8'h0B, 8'h0C, 8'hAA);
        idle(20);
        chk_outs("after_tmo", 24'h0A0B0C, 2, 8'h15);
        chk_lit("after_tmo_fv", fv_cnt, 3);

        bus.uart_rxd = 1'b0;
        idle(BPS / 2 - 6);
        bus.uart_rxd = 1'b1;
        idle(2 * BPS);
        chk_lit("glitch_rxd", rxd_cnt, 40);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h12, 1'b0);
        idle(20);
        chk_lit("stoperr_fe", fe_cnt, 4);
        send_frame(8'h01, 8'h2A, 8'h12, 8'h34, 8'h56, 8'hAA);
        idle(20);
        chk_outs("after_stoperr", 24'h123456, 1, 8'h2A);
        chk_lit("after_stoperr_fv", fv_cnt, 4);

        send_byte(8'hFF, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h2A, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(5);
        sys_rst = 1'b0;
        idle(3);
        chk_outs("midrst", 0, 0, 0);
        chk_lit("midrst_rx_data", int'(bus.rx_data), 0);
        sys_rst = 1'b1;
        idle(10);
        send_frame(8'h01, 8'h2A, 8'h12, 8'h34, 8'h56, 8'hAA);
        idle(20);
        chk_outs("after_rst", 24'h123456, 1, 8'h2A);
        chk_lit("final_fv", fv_cnt, 5);
        chk_lit("final_fe", fe_cnt, 4);
        chk_lit("final_rxd", rxd_cnt, 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
